// File: rtl/alien_bomb_scheduler_if.sv
// rtl/alien_bomb_scheduler_if.sv - spawn-point handshake between bomb scheduler and bomb datapath
interface alien_bomb_scheduler_if #(
    parameter int COL_W = 1
);
    logic                launchReq;
    logic                launchAck;
    logic                bombBusy;
    logic signed [10:0]  xBomb;
    logic        [9:0]   yBomb;
    logic [COL_W-1:0]    shooterCol;
    logic                noTarget;

    modport master (
        output launchReq,
        output xBomb,
        output yBomb,
        output shooterCol,
        output noTarget,
        input  launchAck,
        input  bombBusy
    );

    modport slave (
        input  launchReq,
        input  xBomb,
        input  yBomb,
        input  shooterCol,
        input  noTarget,
        output launchAck,
        output bombBusy
    );
endinterface

// File: rtl/alien_bomb_scheduler.sv
// rtl/alien_bomb_scheduler.sv - round-robin scheduler for the single shared alien bomb
module alien_bomb_scheduler #(
    parameter int NB_LIN    = 2,
    parameter int NB_COL    = 2,
    parameter int COL_PITCH = 40,
    parameter int LIN_PITCH = 30,
    parameter int ALIEN_W   = 20,
    parameter int ALIEN_H   = 16,
    parameter int COOLDOWN  = 50
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       halt,
    input  logic [NB_LIN*NB_COL-1:0]   alive,
    input  logic signed [10:0]         xAlien,
    input  logic        [9:0]          yAlien,
    alien_bomb_scheduler_if.master     bomb
);

    localparam int COL_W = (NB_COL > 1) ? $clog2(NB_COL) : 1;
    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NB_COL - 1);
    localparam logic [10:0]      HALF_W    = 11'(ALIEN_W / 2);
    localparam logic [9:0]       SPRITE_H  = 10'(ALIEN_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_SCAN,
        S_LAUNCH,
        S_FLIGHT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [COL_W-1:0]   scan_idx_q, scan_idx_d;
    logic [COL_W-1:0]   scan_step_q, scan_step_d;
    logic               launch_req_q, launch_req_d;
    logic signed [10:0] x_bomb_q, x_bomb_d;
    logic [9:0]         y_bomb_q, y_bomb_d;
    logic [COL_W-1:0]   shooter_col_q, shooter_col_d;
    logic               no_target_q, no_target_d;

    logic               col_hit;
    logic [10:0]        col_off;
    logic [9:0]         row_off;
    logic [COL_W-1:0]   next_idx;

    // Offsets come from constant products selected by the scanned column; the
    // row loop keeps the last live row, i.e. the bottom-most one.
    always_comb begin
        col_hit = 1'b0;
        col_off = '0;
        row_off = '0;
        for (int c = 0; c < NB_COL; c++) begin
            if (scan_idx_q == COL_W'(c)) begin
                col_off = 11'(c * COL_PITCH);
                for (int l = 0; l < NB_LIN; l++) begin
                    if (alive[l*NB_COL + c]) begin
                        col_hit = 1'b1;
                        row_off = 10'(l * LIN_PITCH);
                    end
                end
            end
        end
    end

    assign next_idx = (scan_idx_q == LAST_COL) ? '0 : scan_idx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        scan_idx_d    = scan_idx_q;
        scan_step_d   = scan_step_q;
        launch_req_d  = launch_req_q;
        x_bomb_d      = x_bomb_q;
        y_bomb_d      = y_bomb_q;
        shooter_col_d = shooter_col_q;
        no_target_d   = no_target_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_COOLDOWN;
                cnt_d   = CNT_INIT;
            end
            S_COOLDOWN: begin
                if (enable) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d     = S_SCAN;
                        scan_idx_d  = rr_ptr_q;
                        scan_step_d = '0;
                    end
                end
            end
            S_SCAN: begin
                if (col_hit) begin
                    x_bomb_d      = xAlien + col_off + HALF_W;
                    y_bomb_d      = yAlien + row_off + SPRITE_H;
                    shooter_col_d = scan_idx_q;
                    rr_ptr_d      = next_idx;
                    no_target_d   = 1'b0;
                    launch_req_d  = 1'b1;
                    state_d       = S_LAUNCH;
                end else if (scan_step_q == LAST_COL) begin
                    no_target_d = 1'b1;
                    state_d     = S_COOLDOWN;
                    cnt_d       = CNT_INIT;
                end else begin
                    scan_idx_d  = next_idx;
                    scan_step_d = scan_step_q + 1'b1;
                end
            end
            S_LAUNCH: begin
                if (bomb.launchAck) begin
                    launch_req_d = 1'b0;
                    state_d      = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                // First FLIGHT cycle already follows the ack cycle.
                if (!bomb.bombBusy) begin
                    state_d = S_COOLDOWN;
                    cnt_d   = CNT_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (halt) begin
            state_d      = S_IDLE;
            launch_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            scan_idx_q    <= '0;
            scan_step_q   <= '0;
            launch_req_q  <= 1'b0;
            x_bomb_q      <= '0;
            y_bomb_q      <= '0;
            shooter_col_q <= '0;
            no_target_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            scan_idx_q    <= scan_idx_d;
            scan_step_q   <= scan_step_d;
            launch_req_q  <= launch_req_d;
            x_bomb_q      <= x_bomb_d;
            y_bomb_q      <= y_bomb_d;
            shooter_col_q <= shooter_col_d;
            no_target_q   <= no_target_d;
        end
    end

    assign bomb.launchReq  = launch_req_q;
    assign bomb.xBomb      = x_bomb_q;
    assign bomb.yBomb      = y_bomb_q;
    assign bomb.shooterCol = shooter_col_q;
    assign bomb.noTarget   = no_target_q;

endmodule

// File: tb/tb_alien_bomb_scheduler.sv
// tb/tb_alien_bomb_scheduler.sv - directed bench for alien_bomb_scheduler with a small bomb datapath model
module tb_alien_bomb_scheduler;

    logic               clk;
    logic               reset;
    logic               enable;
    logic               halt;
    logic [3:0]         alive;
    logic signed [10:0] xAlien;
    logic [9:0]         yAlien;

    int pass_cnt;
    int total;
    int en_cnt;
    int en_edges;
    int since_en;
    int busy_left;
    bit en_run;
    bit auto_ack;
    bit req_prev;

    alien_bomb_scheduler_if #(.COL_W(1)) bif ();

    alien_bomb_scheduler #(
        .NB_LIN   (2),
        .NB_COL   (2),
        .COL_PITCH(40),
        .LIN_PITCH(30),
        .ALIEN_W  (20),
        .ALIEN_H  (16),
        .COOLDOWN (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .halt  (halt),
        .alive (alive),
        .xAlien(xAlien),
        .yAlien(yAlien),
        .bomb  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: inputs change 1 time unit after the edge, outputs are read there too.
    task automatic tick();
        logic en_now;
        en_now = enable;
        @(posedge clk);
        #1;
        if (en_now) begin
            en_edges++;
            since_en = 0;
        end else begin
            since_en++;
        end
        if (bif.launchAck) begin
            bif.launchAck = 1'b0;
            bif.bombBusy  = 1'b1;
            busy_left     = 5;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bif.bombBusy = 1'b0;
        end
        if (auto_ack && bif.launchReq && req_prev) bif.launchAck = 1'b1;
        req_prev = bif.launchReq;
        en_cnt++;
        enable = en_run && (en_cnt % 4 == 0);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!bif.launchReq && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(bif.launchReq), 32'd1);
    endtask

    task automatic wait_drop(input string tag);
        int n;
        n = 0;
        while (bif.launchReq && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_drop"}, 32'(bif.launchReq), 32'd0);
    endtask

    task automatic chk_launch(input string tag, input int col, input int x, input int y);
        chk({tag, "_col"}, 32'(bif.shooterCol), 32'(col));
        chk({tag, "_x"}, 32'(bif.xBomb), 32'(x));
        chk({tag, "_y"}, 32'(bif.yBomb), 32'(y));
        chk({tag, "_nt"}, 32'(bif.noTarget), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        int reqs;
        pass_cnt = 0;
        total    = 0;
        en_cnt   = 0;
        en_edges = 0;
        since_en = 0;
        busy_left = 0;
        en_run   = 1'b0;
        auto_ack = 1'b0;
        req_prev = 1'b0;
        reset    = 1'b1;
        enable   = 1'b0;
        halt     = 1'b0;
        alive    = 4'b1111;
        xAlien   = 11'sd100;
        yAlien   = 10'd50;
        bif.launchAck = 1'b0;
        bif.bombBusy  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bif.launchReq), 32'd0);
        chk("rst_x", 32'(bif.xBomb), 32'd0);
        chk("rst_y", 32'(bif.yBomb), 32'd0);
        chk("rst_col", 32'(bif.shooterCol), 32'd0);
        chk("rst_nt", 32'(bif.noTarget), 32'd0);

        reset    = 1'b0;
        en_run   = 1'b1;
        auto_ack = 1'b1;

        // First launch after three enables, column 0, bottom row 1.
        wait_req("l1");
        chk("l1_enables", 32'(en_edges), 32'd3);
        chk_launch("l1", 0, 110, 96);
        wait_drop("l1");

        wait_req("l2");
        chk_launch("l2", 1, 150, 96);
        wait_drop("l2");

        wait_req("l3");
        chk_launch("l3", 0, 110, 96);
        alive = 4'b0010;
        wait_drop("l3");

        // Only lin0/col1 alive: direct hit, then a hit after skipping column 0.
        wait_req("l4");
        chk("l4_lat", 32'(since_en), 32'd1);
        chk_launch("l4", 1, 150, 66);
        wait_drop("l4");

        wait_req("l5");
        chk("l5_lat", 32'(since_en), 32'd2);
        chk_launch("l5", 1, 150, 66);
        alive = 4'b0000;
        wait_drop("l5");

        n = 0;
        while (!bif.noTarget && n < 300) begin
            tick();
            n++;
        end
        chk("nt_set", 32'(bif.noTarget), 32'd1);
        chk("nt_req", 32'(bif.launchReq), 32'd0);
        reqs = 0;
        repeat (40) begin
            tick();
            if (bif.launchReq) reqs++;
        end
        chk("nt_noreq", 32'(reqs), 32'd0);
        chk("nt_hold", 32'(bif.noTarget), 32'd1);

        alive = 4'b0001;
        wait_req("l6");
        chk_launch("l6", 0, 110, 66);

        // Ack withheld while the formation moves: spawn point stays frozen.
        auto_ack = 1'b0;
        xAlien   = 11'sd300;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_req", 32'(bif.launchReq), 32'd1);
            chk("hold_x", 32'(bif.xBomb), 32'd110);
        end
        auto_ack = 1'b1;
        wait_drop("l6");
        chk("l6_x_after", 32'(bif.xBomb), 32'd110);
        xAlien = 11'sd100;

        alive    = 4'b1111;
        auto_ack = 1'b0;
        wait_req("l7");
        chk_launch("l7", 1, 150, 96);
        halt = 1'b1;
        tick();
        chk("halt_req", 32'(bif.launchReq), 32'd0);
        chk("halt_x", 32'(bif.xBomb), 32'd150);
        chk("halt_col", 32'(bif.shooterCol), 32'd1);
        reqs = 0;
        repeat (20) begin
            tick();
            if (bif.launchReq) reqs++;
        end
        chk("halt_idle", 32'(reqs), 32'd0);
        halt     = 1'b0;
        auto_ack = 1'b1;
        wait_req("l8");
        chk_launch("l8", 0, 110, 96);
        alive = 4'b0000;
        wait_drop("l8");

        n = 0;
        while (!bif.noTarget && n < 300) begin
            tick();
            n++;
        end
        chk("nt2_set", 32'(bif.noTarget), 32'd1);
        base = en_edges;
        n = 0;
        while (en_edges < base + 3 && n < 100) begin
            tick();
            n++;
        end
        chk("scan_enables", 32'(en_edges), 32'(base + 3));
        chk("pre_rst_x", 32'(bif.xBomb), 32'd110);

        // Asynchronous reset while the scan is in progress.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(bif.launchReq), 32'd0);
        chk("arst_x", 32'(bif.xBomb), 32'd0);
        chk("arst_y", 32'(bif.yBomb), 32'd0);
        chk("arst_col", 32'(bif.shooterCol), 32'd0);
        chk("arst_nt", 32'(bif.noTarget), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/alien_bomb_scheduler.md
Name: alien_bomb_scheduler

Overview:
- Schedules the single shared alien bomb among the alien columns, round-robin.
- Per launch: picks the next column holding a live alien, selects that column's bottom-most live alien, computes the bomb spawn point from the formation origin, and hands it to the bomb datapath through a req/ack handshake.
- Sits beside the alien motion/colour logic. Consumes the formation origin and alive mask; drives the bomb-falling datapath.

Parameters:
- NB_LIN, 2, alien rows.
- NB_COL, 2, alien columns; alive index = lin*NB_COL + col.
- COL_PITCH, 40, horizontal pixel distance between column origins.
- LIN_PITCH, 30, vertical pixel distance between row origins.
- ALIEN_W, 20, alien sprite width in pixels.
- ALIEN_H, 16, alien sprite height in pixels.
- COOLDOWN, 50, enable ticks between end of one bomb and next scan; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  one-cycle game tick pulse; times the cooldown only.
- halt  input  1  game over (victory|defeat); forces IDLE.
- alive  input  NB_ALIENS  alive mask, NB_ALIENS = NB_LIN*NB_COL.
- xAlien  input  11 signed  formation origin x.
- yAlien  input  10  formation origin y.
- launchAck  input  1  bomb datapath accepted the spawn point.
- bombBusy  input  1  bomb in flight.
- launchReq  output  1  spawn request.
- xBomb  output  11 signed  spawn x.
- yBomb  output  10  spawn y.
- shooterCol  output  clog2(NB_COL) (min 1)  column of last launch.
- noTarget  output  1  last full scan found no live alien.

Behaviour:
- Reset (async): state IDLE; launchReq=0, xBomb=0, yBomb=0, shooterCol=0, noTarget=0, rrPtr=0, cooldown counter=0.
- States: IDLE, COOLDOWN, SCAN, LAUNCH, FLIGHT.
- IDLE: if halt=0, next cycle -> COOLDOWN with counter=COOLDOWN.
- COOLDOWN:
  - Counter decrements on each clk with enable=1.
  - When counter is 1 and enable=1 -> SCAN, with scan index=rrPtr and step=0.
- SCAN:
  - Examines one column per clk cycle.
  - Column c hit = any alive[l*NB_COL+c].
  - On a hit, with l = largest live row in c (bottom-most):
    - xBomb = xAlien + c*COL_PITCH + ALIEN_W/2, 11-bit signed wrap.
    - yBomb = yAlien + l*LIN_PITCH + ALIEN_H, 10-bit truncation.
    - shooterCol = c; rrPtr = (c+1) mod NB_COL; noTarget = 0.
    - launchReq = 1; next state LAUNCH.
  - On a miss: index = (index+1) mod NB_COL, step+1.
  - After NB_COL misses: noTarget=1, rrPtr unchanged, -> COOLDOWN with counter=COOLDOWN.
  - Scan latency: 1..NB_COL cycles.
- LAUNCH:
  - launchReq, xBomb and yBomb hold stable until launchAck=1.
  - The spawn point is frozen even if xAlien, yAlien or alive change meanwhile.
  - Cycle with launchAck=1: launchReq drops next edge; -> FLIGHT.
- FLIGHT: wait for bombBusy=0 sampled on a cycle after the ack cycle, then -> COOLDOWN with counter=COOLDOWN.
- Ack arrives while bombBusy=0: FLIGHT still waits at least one cycle, then returns to COOLDOWN.
- halt=1 in any state: next edge -> IDLE, launchReq=0.
  - xBomb, yBomb, shooterCol, rrPtr and noTarget keep their values.
  - A pending request is abandoned; a bomb already in flight is not tracked.
- enable pulses outside COOLDOWN are ignored.
- launchAck while launchReq=0 is ignored.
- Reset mid-operation: immediate return to reset values regardless of state.
- A single NB_LIN-wide priority encoder per column is sufficient; no multiplier on the dynamic path. c*COL_PITCH and l*LIN_PITCH are constant-indexed.

Test Plan (NB_LIN=2, NB_COL=2, COOLDOWN=3, default geometry; the bench acks 1 cycle after launchReq and pulses bombBusy for 5 cycles):
- Reset with alive=4'b1111, xAlien=100, yAlien=50, enable every 4 clk -> after the 3rd enable, launchReq=1, shooterCol=0, xBomb=110, yBomb=96.
- After the first bomb's bombBusy falls, the next launch is from column 1 -> xBomb=150, yBomb=96; the third launch is from column 0 again.
- alive=4'b0010 (only lin0 col1) -> launches repeat from column 1 with yBomb=66; column 0 is skipped in 2 scan cycles.
- alive=0 -> no launchReq, noTarget=1 after the scan; rescans every 3 enables. Setting alive=4'b0001 then yields a launch from column 0 and clears noTarget.
- Withhold launchAck for 20 cycles while changing xAlien to 300 -> launchReq stays 1 and xBomb stays 110 until the ack.
- halt=1 during LAUNCH -> launchReq=0 the next cycle and the state is IDLE. Async reset asserted mid-SCAN -> all outputs 0 immediately.
